alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 12-bit ALU (ops: clr=0, pass=1, add=2, sub=3, mul=4, inc=5) between NUM_REQ core-side requesters.
- Round-robin arbitration with a req/done handshake.
- Latches the winner's operands and opcode, and holds them on the ALU inputs for 1 cycle, or MUL_CYCLES cycles for mul.
- Registers the ALU result and returns it with a one-cycle done strobe. Sits between the core control units and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 12, operand/result width.
- MUL_CYCLES, 2, cycles operands are held stable for mul (1..8); all other ops use 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rstN  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester level request; held until own done.
- a_in  input  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH].
- b_in  input  NUM_REQ*WIDTH  operand b, same packing.
- op_in  input  NUM_REQ*3  opcode, requester i at [i*3 +: 3].
- alu_result  input  WIDTH  from shared ALU dataOut.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_op  output  3  to ALU selectOp.
- grant  output  NUM_REQ  one-hot, high for the whole EXEC phase of the owner.
- done  output  NUM_REQ  one-hot, one-cycle pulse in RESP.
- result  output  WIDTH  registered result; valid while done is high, holds its value until the next RESP.
- op_err  output  1  one-cycle pulse, coincident with done, when the latched opcode is 6 or 7.
- busy  output  1  high in EXEC and RESP.

Behaviour:
- Reset (async, any state): FSM to IDLE. alu_a=alu_b=0, alu_op=clr, grant=0, done=0, result=0, op_err=0, busy=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, EXEC, RESP.
- IDLE:
  - ALU outputs driven 0/clr.
  - If any req bit is set: winner = first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - On the edge: latch winner's a/b/op into operand regs, set grant[winner], last<=winner, cnt<=(op==mul)?MUL_CYCLES-1:0, go EXEC.
  - If no req bit is set: stay in IDLE.
- EXEC:
  - alu_a/alu_b/alu_op driven from the operand regs, stable for the whole phase.
  - Opcodes 6/7 are driven to the ALU as clr.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: result<=alu_result (forced 0 for op 6/7), grant<=0, done[owner]<=1, op_err<=(op>5), go RESP.
- RESP:
  - done/result valid for exactly one cycle.
  - ALU outputs return to 0/clr.
  - Next state is IDLE unconditionally; no back-to-back grant from RESP.
- Latency, req sampled high in IDLE at edge k:
  - grant high in cycle k+1.
  - Non-mul: done in cycle k+2.
  - mul: done in cycle k+1+MUL_CYCLES.
  - Throughput: one op per 3 cycles (non-mul).
- Handshake:
  - A requester keeps req and its operands stable from assertion until it sees done.
  - It must drop req at the edge after done unless it issues a new op.
  - Operand or req changes during EXEC are ignored, because operands are latched.
- Fairness:
  - The just-served requester has lowest priority in the next IDLE.
  - With all NUM_REQ requesting continuously, grants rotate 0,1,2,3,0,...
- Arithmetic:
  - Results are the ALU's WIDTH-bit values, passed through unmodified.
  - mul is truncated to WIDTH bits; add/sub/inc wrap modulo 2^WIDTH.
- Deassertion of an owner's req mid-EXEC does not abort the op; done is still issued.
- Reset asserted mid-EXEC: op discarded, no done. After reset release, the first grant goes to the lowest-index requester with req set.

Test Plan:
- Reset then idle: rstN low 3 cycles with req=4'b1111 → all outputs 0, alu_op=0. Release → first grant=4'b0001.
- Single add: req[2]=1, a=12'd100, b=12'd23, op=2 → grant[2] high 1 cycle, done[2] 2 cycles after sampling edge, result=12'd123, op_err=0.
- Mul hold and wrap: MUL_CYCLES=2, req[1], a=12'd100, b=12'd50, op=4 → alu_op=4 stable 2 cycles, done[1] at k+3, result=12'd904 (5000 mod 4096). Then sub a=0,b=1 → result=12'hFFF.
- Round robin: all four req held with op=5, a_i=i → done order 0,1,2,3,0. Results 1,2,3,4. Each done exactly 3 cycles apart.
- Invalid op plus mid-op reset: op=7 → alu_op=0 during EXEC, result=0, op_err pulses with done. Then start mul, pull rstN low in EXEC → no done, busy=0 immediately, pointer restored to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between NUM_REQ requesters.
// Latches the winner's operands, holds them on the ALU for 1 (or MUL_CYCLES for mul) cycles, returns a registered result.
module alu_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    input  logic [NUM_REQ*3-1:0]     op_in,
    input  logic [WIDTH-1:0]         alu_result,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_op,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         result,
    output logic                     op_err,
    output logic                     busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd5;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               op_err_q, op_err_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic [2:0]         win_op;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        found  = 1'b0;
        win    = last_q;
        win_a  = '0;
        win_b  = '0;
        win_op = OP_CLR;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            automatic int idx = (int'(last_q) + k) % int'(NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                win    = IDX_W'(idx);
                win_a  = a_in[idx*WIDTH +: WIDTH];
                win_b  = b_in[idx*WIDTH +: WIDTH];
                win_op = op_in[idx*3 +: 3];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        op_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d  = S_EXEC;
                    last_d   = win;
                    op_d     = win_op;
                    alu_a_d  = win_a;
                    alu_b_d  = win_b;
                    alu_op_d = (win_op > OP_MAX) ? OP_CLR : win_op;
                    grant_d  = NUM_REQ'(1) << win;
                    cnt_d    = (win_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d  = S_RESP;
                    result_d = (op_q > OP_MAX) ? '0 : alu_result;
                    op_err_d = (op_q > OP_MAX);
                    done_d   = grant_q;
                    grant_d  = '0;
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                    alu_op_d = OP_CLR;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                alu_a_d  = '0;
                alu_b_d  = '0;
                alu_op_d = OP_CLR;
            end
        endcase

        busy_d = (state_d == S_EXEC) || (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            last_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            op_q     <= OP_CLR;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_CLR;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            op_err_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_err_q <= op_err_d;
            busy_q   <= busy_d;
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign grant  = grant_q;
    assign done   = done_q;
    assign result = result_q;
    assign op_err = op_err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int NR = 4;
    localparam int W  = 12;
    localparam int MC = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic [NR-1:0] req;
    logic [NR*W-1:0] a_in, b_in;
    logic [NR*3-1:0] op_in;
    logic [W-1:0]  alu_result, alu_a, alu_b, result;
    logic [2:0]    alu_op;
    logic [NR-1:0] grant, done;
    logic          op_err, busy;

    int n_cmp = 0;
    int n_err = 0;
    int m_last;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rstN(rstN), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .grant(grant), .done(done), .result(result), .op_err(op_err), .busy(busy)
    );

    // Stand-in for the shared ALU; unknown opcodes give a nonzero garbage value.
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = '0;
            3'd1:    alu_result = alu_a;
            3'd2:    alu_result = W'(alu_a + alu_b);
            3'd3:    alu_result = W'(alu_a - alu_b);
            3'd4:    alu_result = W'(alu_a * alu_b);
            3'd5:    alu_result = W'(alu_a + W'(1));
            default: alu_result = 12'hBAD;
        endcase
    end

    function automatic int ref_alu(int a, int b, int op);
        case (op)
            1:       return a;
            2:       return (a + b) % 4096;
            3:       return (a - b + 4096) % 4096;
            4:       return (a * b) % 4096;
            5:       return (a + 1) % 4096;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_winner(int last, logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_op(int i, int a, int b, int op);
        a_in[i*W +: W]  = W'(a);
        b_in[i*W +: W]  = W'(b);
        op_in[i*3 +: 3] = 3'(op);
    endtask

    task automatic wait_grant(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            n++;
            if (grant != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            n++;
            if (done != '0) ok = 1'b1;
        end
    endtask

    task automatic go_idle();
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        m_last = NR - 1;
    endtask

    task automatic test_reset();
        int n; bit ok;
        rstN = 1'b0;
        req  = '1;
        for (int i = 0; i < NR; i++) set_op(i, i, 1, 2);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({alu_a, alu_b, grant, done, result, op_err, busy} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got a=%h b=%h g=%b d=%b r=%h e=%b busy=%b want all 0",
                              alu_a, alu_b, grant, done, result, op_err, busy);
        end
        n_cmp++;
        if (alu_op !== 3'd0) begin n_err++; $display("FAIL reset_alu_op: got %0d want 0", alu_op); end
        rstN = 1'b1;
        m_last = NR - 1;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
        wait_done(n, ok);
        n_cmp++;
        if (!ok || done !== 4'b0001 || result !== W'(ref_alu(0, 1, 2))) begin
            n_err++; $display("FAIL reset_first_done: got done=%b result=%h want 0001/%h", done, result, W'(ref_alu(0, 1, 2)));
        end
        m_last = 0;
        req = '0;
    endtask

    task automatic test_single_add();
        go_idle();
        set_op(2, 100, 23, 2);
        req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0100 || alu_a !== 12'd100 || alu_b !== 12'd23 || alu_op !== 3'd2 || busy !== 1'b1) begin
            n_err++; $display("FAIL add_exec: got g=%b a=%0d b=%0d op=%0d busy=%b want 0100/100/23/2/1", grant, alu_a, alu_b, alu_op, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0100 || result !== 12'd123 || op_err !== 1'b0 || grant !== 4'b0000 || alu_op !== 3'd0) begin
            n_err++; $display("FAIL add_resp: got d=%b r=%0d e=%b g=%b op=%0d want 0100/123/0/0000/0", done, result, op_err, grant, alu_op);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0000 || result !== 12'd123 || busy !== 1'b0) begin
            n_err++; $display("FAIL add_after: got d=%b r=%0d busy=%b want 0000/123/0", done, result, busy);
        end
        m_last = 2;
    endtask

    task automatic test_mul_wrap();
        int n; bit ok;
        go_idle();
        set_op(1, 100, 50, 4);
        req = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010 || alu_op !== 3'd4 || done !== '0) begin
            n_err++; $display("FAIL mul_cycle1: got g=%b op=%0d d=%b want 0010/4/0000", grant, alu_op, done);
        end
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010 || alu_op !== 3'd4 || alu_a !== 12'd100 || done !== '0) begin
            n_err++; $display("FAIL mul_cycle2: got g=%b op=%0d a=%0d d=%b want 0010/4/100/0000", grant, alu_op, alu_a, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b0010 || result !== 12'd904) begin
            n_err++; $display("FAIL mul_result: got d=%b r=%0d want 0010/904", done, result);
        end
        go_idle();
        set_op(1, 0, 1, 3);
        req = 4'b0010;
        wait_done(n, ok);
        n_cmp++;
        if (!ok || result !== 12'hFFF) begin n_err++; $display("FAIL sub_wrap: got %h want fff", result); end
        req = '0;
        m_last = 1;
    endtask

    task automatic test_round_robin();
        int n, exp; bit ok;
        go_idle();
        pulse_reset();
        for (int i = 0; i < NR; i++) set_op(i, i, $urandom_range(4095), 5);
        req = '1;
        for (int j = 0; j < 5; j++) begin
            wait_done(n, ok);
            exp = ref_winner(m_last, req);
            n_cmp++;
            if (!ok || done !== NR'(1 << exp) || result !== W'(exp + 1)) begin
                n_err++; $display("FAIL rr_done%0d: got d=%b r=%0d want %b/%0d", j, done, result, NR'(1 << exp), exp + 1);
            end
            if (j > 0) begin
                n_cmp++;
                if (n !== 3) begin n_err++; $display("FAIL rr_spacing%0d: got %0d cycles want 3", j, n); end
            end
            m_last = exp;
        end
        req = '0;
    endtask

    task automatic test_invalid_and_reset();
        int n, exp; bit ok, seen;
        go_idle();
        set_op(3, 5, 6, 7);
        req = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b1000 || alu_op !== 3'd0) begin
            n_err++; $display("FAIL inv_exec: got g=%b op=%0d want 1000/0", grant, alu_op);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 4'b1000 || result !== 12'd0 || op_err !== 1'b1) begin
            n_err++; $display("FAIL inv_resp: got d=%b r=%0d e=%b want 1000/0/1", done, result, op_err);
        end
        req = '0;
        m_last = 3;
        @(negedge clk);
        n_cmp++;
        if (op_err !== 1'b0) begin n_err++; $display("FAIL inv_err_pulse: got %b want 0", op_err); end

        go_idle();
        set_op(2, 9, 9, 4);
        set_op(1, 7, 3, 2);
        req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0100) begin n_err++; $display("FAIL rst_grant: got %b want 0100", grant); end
        rstN = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || grant !== '0 || alu_op !== 3'd0) begin
            n_err++; $display("FAIL rst_mid_exec: got busy=%b g=%b op=%0d want 0/0000/0", busy, grant, alu_op);
        end
        req  = 4'b0110;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_no_done: got done seen=%b want 0", seen); end
        rstN = 1'b1;
        m_last = NR - 1;
        exp = ref_winner(m_last, req);
        @(negedge clk);
        n_cmp++;
        if (grant !== NR'(1 << exp)) begin n_err++; $display("FAIL rst_pointer: got %b want %b", grant, NR'(1 << exp)); end
        wait_done(n, ok);
        n_cmp++;
        if (!ok || done !== NR'(1 << exp) || result !== W'(ref_alu(7, 3, 2))) begin
            n_err++; $display("FAIL rst_after_op: got d=%b r=%0d want %b/%0d", done, result, NR'(1 << exp), ref_alu(7, 3, 2));
        end
        req = '0;
        m_last = exp;
    endtask

    task automatic test_random();
        int ta[NR], tb_[NR], top[NR];
        logic [NR-1:0] pend;
        int n, exp, expr, lat; bit ok;
        go_idle();
        pulse_reset();
        pend = '0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom_range(1) == 1)) begin
                    ta[i] = $urandom_range(4095); tb_[i] = $urandom_range(4095); top[i] = $urandom_range(7);
                    set_op(i, ta[i], tb_[i], top[i]);
                    pend[i] = 1'b1;
                end
            end
            if (pend == '0) begin
                ta[0] = $urandom_range(4095); tb_[0] = $urandom_range(4095); top[0] = 4;
                set_op(0, ta[0], tb_[0], top[0]);
                pend[0] = 1'b1;
            end
            req  = pend;
            exp  = ref_winner(m_last, pend);
            expr = ref_alu(ta[exp], tb_[exp], top[exp]);
            lat  = (top[exp] == 4) ? MC : 1;
            wait_grant(n, ok);
            n_cmp++;
            if (!ok || grant !== NR'(1 << exp)) begin
                n_err++; $display("FAIL rnd_grant%0d: got %b want %b", it, grant, NR'(1 << exp));
            end
            if ($urandom_range(1) == 1) set_op(exp, $urandom_range(4095), $urandom_range(4095), $urandom_range(7));
            wait_done(n, ok);
            n_cmp++;
            if (!ok || done !== NR'(1 << exp) || result !== W'(expr) || op_err !== (top[exp] > 5) || n !== lat) begin
                n_err++; $display("FAIL rnd_done%0d: got d=%b r=%h e=%b lat=%0d want %b/%h/%b/%0d",
                                  it, done, result, op_err, n, NR'(1 << exp), W'(expr), top[exp] > 5, lat);
            end
            pend[exp] = 1'b0;
            req = pend;
            m_last = exp;
        end
        req = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req = '0; a_in = '0; b_in = '0; op_in = '0; rstN = 1'b0;
        m_last = NR - 1;
        test_reset();
        test_single_add();
        test_mul_wrap();
        test_round_robin();
        test_invalid_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
